// File: rtl/noc_router_xy.sv
// rtl/noc_router_xy.sv - 5-port single-flit XY dimension-order mesh router
//
// Ports (index 0 Local, 1 North, 2 East, 3 South, 4 West):
//   clk, rst_n          : clock, synchronous active-low reset
//   flit_in/valid_in    : inbound flits; accepted when valid_in && ready_out
//   ready_out           : input FIFO has space (and not in reset)
//   flit_out/valid_out  : registered outbound stage, held while !ready_in
//   ready_in            : downstream accepts outbound flit
//   route_err           : one-cycle pulse after a U-turn flit is accepted
module noc_router_xy #(
    parameter int FLIT_W     = 64,
    parameter int FIFO_DEPTH = 4,
    parameter int COORD_W    = 4,
    parameter int MY_X       = 0,
    parameter int MY_Y       = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [FLIT_W-1:0] flit_in   [5],
    input  logic              valid_in  [5],
    output logic              ready_out [5],
    output logic [FLIT_W-1:0] flit_out  [5],
    output logic              valid_out [5],
    input  logic              ready_in  [5],
    output logic              route_err [5]
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [2:0] P_LOCAL = 3'd0;
    localparam logic [2:0] P_NORTH = 3'd1;
    localparam logic [2:0] P_EAST  = 3'd2;
    localparam logic [2:0] P_SOUTH = 3'd3;
    localparam logic [2:0] P_WEST  = 3'd4;

    localparam logic [COORD_W-1:0] MY_X_C = COORD_W'(MY_X);
    localparam logic [COORD_W-1:0] MY_Y_C = COORD_W'(MY_Y);

    // X is resolved fully before Y, which keeps the mesh deadlock-free.
    function automatic logic [2:0] route_of(input logic [FLIT_W-1:0] f);
        logic [COORD_W-1:0] dx;
        logic [COORD_W-1:0] dy;
        dx = f[COORD_W-1:0];
        dy = f[2*COORD_W-1:COORD_W];
        if (dx > MY_X_C)      return P_EAST;
        else if (dx < MY_X_C) return P_WEST;
        else if (dy > MY_Y_C) return P_NORTH;
        else if (dy < MY_Y_C) return P_SOUTH;
        else                  return P_LOCAL;
    endfunction

    logic [FLIT_W-1:0] mem_q        [5][FIFO_DEPTH];
    logic [FLIT_W-1:0] mem_d        [5][FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q     [5];
    logic [PTR_W-1:0]  rd_ptr_d     [5];
    logic [PTR_W-1:0]  wr_ptr_q     [5];
    logic [PTR_W-1:0]  wr_ptr_d     [5];
    logic [CNT_W-1:0]  count_q      [5];
    logic [CNT_W-1:0]  count_d      [5];
    logic [FLIT_W-1:0] out_flit_q   [5];
    logic [FLIT_W-1:0] out_flit_d   [5];
    logic              out_valid_q  [5];
    logic              out_valid_d  [5];
    logic [2:0]        last_grant_q [5];
    logic [2:0]        last_grant_d [5];
    logic              route_err_q  [5];
    logic              route_err_d  [5];

    logic              accept     [5];
    logic              pop        [5];
    logic              head_valid [5];
    logic [FLIT_W-1:0] head_flit  [5];
    logic [2:0]        head_route [5];
    logic              load_en    [5];
    logic              gnt_valid  [5];
    logic [2:0]        gnt_idx    [5];
    logic [4:0]        req        [5];

    // FIFO heads and acceptance. ready_out looks only at the registered
    // count, so a full FIFO refuses even when it pops on the same edge.
    always_comb begin
        for (int p = 0; p < 5; p++) begin
            head_flit[p]  = mem_q[p][rd_ptr_q[p]];
            head_valid[p] = (count_q[p] != '0);
            head_route[p] = route_of(head_flit[p]);
            ready_out[p]  = (count_q[p] < CNT_W'(FIFO_DEPTH)) && rst_n;
            accept[p]     = valid_in[p] && ready_out[p];
        end
    end

    // Per-output round-robin, searching from last_grant+1.
    always_comb begin
        logic [2:0] idx;
        idx = 3'd0;
        for (int o = 0; o < 5; o++) begin
            load_en[o]   = !out_valid_q[o] || ready_in[o];
            gnt_valid[o] = 1'b0;
            gnt_idx[o]   = 3'd0;
            req[o]       = '0;
            for (int p = 0; p < 5; p++) begin
                req[o][p] = head_valid[p] && (head_route[p] == 3'(o));
            end
            for (int k = 0; k < 5; k++) begin
                idx = 3'((int'(last_grant_q[o]) + 1 + k) % 5);
                if (!gnt_valid[o] && req[o][idx]) begin
                    gnt_valid[o] = 1'b1;
                    gnt_idx[o]   = idx;
                end
            end
        end
    end

    // A head routes to exactly one output, so at most one grant pops it.
    always_comb begin
        for (int p = 0; p < 5; p++) begin
            pop[p] = 1'b0;
        end
        for (int o = 0; o < 5; o++) begin
            if (gnt_valid[o] && load_en[o]) begin
                pop[gnt_idx[o]] = 1'b1;
            end
        end
    end

    always_comb begin
        mem_d        = mem_q;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        count_d      = count_q;
        out_flit_d   = out_flit_q;
        out_valid_d  = out_valid_q;
        last_grant_d = last_grant_q;
        for (int p = 0; p < 5; p++) begin
            if (accept[p]) begin
                mem_d[p][wr_ptr_q[p]] = flit_in[p];
                wr_ptr_d[p]           = wr_ptr_q[p] + PTR_W'(1);
            end
            if (pop[p]) begin
                rd_ptr_d[p] = rd_ptr_q[p] + PTR_W'(1);
            end
            count_d[p]     = count_q[p] + CNT_W'(accept[p]) - CNT_W'(pop[p]);
            // Local (p=0) can never U-turn; a flit for this router exits Local.
            route_err_d[p] = accept[p] && (p != 0) && (route_of(flit_in[p]) == 3'(p));
        end
        for (int o = 0; o < 5; o++) begin
            if (load_en[o]) begin
                out_valid_d[o] = gnt_valid[o];
                if (gnt_valid[o]) begin
                    out_flit_d[o]   = head_flit[gnt_idx[o]];
                    last_grant_d[o] = gnt_idx[o];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int p = 0; p < 5; p++) begin
                rd_ptr_q[p]     <= '0;
                wr_ptr_q[p]     <= '0;
                count_q[p]      <= '0;
                out_flit_q[p]   <= '0;
                out_valid_q[p]  <= 1'b0;
                last_grant_q[p] <= 3'd4;
                route_err_q[p]  <= 1'b0;
            end
        end else begin
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            out_flit_q   <= out_flit_d;
            out_valid_q  <= out_valid_d;
            last_grant_q <= last_grant_d;
            route_err_q  <= route_err_d;
        end
    end

    // Storage needs no reset: emptied counts make stale entries unreachable.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_comb begin
        for (int o = 0; o < 5; o++) begin
            flit_out[o]  = out_flit_q[o];
            valid_out[o] = out_valid_q[o];
            route_err[o] = route_err_q[o];
        end
    end

endmodule

// File: doc/noc_router_xy.md
NOC_ROUTER_XY -- requirements
Module: noc_router_xy

Interface
REQ-001 SHALL have parameter FLIT_W, default 64, flit width in bits.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, input FIFO entries per port (power of 2, >=2).
REQ-003 SHALL have parameter COORD_W, default 4, width of each destination coordinate field.
REQ-004 SHALL have parameter MY_X, default 0, this router's X coordinate.
REQ-005 SHALL have parameter MY_Y, default 0, this router's Y coordinate.
REQ-006 SHALL have port clk  input  1  the only clock; all logic on posedge.
REQ-007 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-008 SHALL have port flit_in[5]  input  FLIT_W  inbound flit per port (0 Local, 1 North, 2 East, 3 South, 4 West).
REQ-009 SHALL have port valid_in[5]  input  1  inbound flit valid.
REQ-010 SHALL have port ready_out[5]  output  1  router can accept on that port.
REQ-011 SHALL have port flit_out[5]  output  FLIT_W  outbound flit per port.
REQ-012 SHALL have port valid_out[5]  output  1  outbound flit valid.
REQ-013 SHALL have port ready_in[5]  input  1  downstream accepts outbound flit.
REQ-014 SHALL have port route_err[5]  output  1  one-cycle pulse per input port: U-turn flit accepted.

Function
REQ-015 SHALL treat every flit as a single-flit packet: dest X = flit[COORD_W-1:0], dest Y = flit[2*COORD_W-1:COORD_W], unsigned.
REQ-016 SHALL route dimension-order XY: dx>MY_X -> East; dx<MY_X -> West; else dy>MY_Y -> North; dy<MY_Y -> South; else Local.
REQ-017 SHALL accept a flit on port p at a posedge where valid_in[p] && ready_out[p]; flit_in[p] is ignored otherwise.
REQ-018 SHALL buffer accepted flits in a per-port FIFO of FIFO_DEPTH entries, preserving order.
REQ-019 SHALL drive ready_out[p] = (count[p] < FIFO_DEPTH) && rst_n; a full FIFO does not accept even if it dequeues the same cycle.
REQ-020 SHALL give each output port a registered stage; it loads when empty or when (valid_out && ready_in) that cycle.
REQ-021 SHALL hold flit_out[o] and valid_out[o] stable while valid_out[o] && !ready_in[o].
REQ-022 SHALL arbitrate each output round-robin among FIFO heads routed to it, starting at (last_grant+1) mod 5.
REQ-023 SHALL update last_grant[o] only when the grant is consumed (output stage loaded); head popped the same edge.
REQ-024 SHALL deliver an uncontended flit with empty FIFO and ready output stage at valid_out two cycles after acceptance (accept edge T, valid_out high after edge T+1).
REQ-025 SHALL sustain one flit per cycle per output under continuous ready_in.
REQ-026 SHALL forward a flit whose computed output equals its input port (U-turn, p!=0) normally and pulse route_err[p] the cycle after acceptance.
REQ-027 SHALL never drop, duplicate or reorder flits sharing an input and output port.

Reset
REQ-028 SHALL, at a posedge with rst_n low: empty all FIFOs, clear valid_out and flit_out to 0, clear route_err to 0, set all last_grant to 4.
REQ-029 SHALL drive ready_out to 0 while rst_n is low and to 1 in the first cycle after release.
REQ-030 SHALL discard all buffered and in-stage flits on reset mid-operation; none emerge after release.

Verification (MY_X=1, MY_Y=1, COORD_W=4, FIFO_DEPTH=4)
REQ-031 SHALL cover: port 0 sends dest (2,1) at edge 0, all ready_in=1 -> valid_out[2]=1 after edge 1 with identical flit, other valid_out 0.
REQ-032 SHALL cover: ports 1,3,4 send dest (1,1) on the same edge after reset -> port 0 emits from 1, 3, 4 on consecutive cycles.
REQ-033 SHALL cover: ready_in[2]=0, port 0 streams 7 flits dest (3,1) -> 5 accepted, ready_out[0]=0, flit_out[2] stable; ready_in[2]=1 -> all delivered in order.
REQ-034 SHALL cover: port 2 sends dest (3,1) -> route_err[2]=1 for one cycle, flit appears on valid_out[2].
REQ-035 SHALL cover: 3 flits queued on port 1, rst_n low one edge -> next cycle all valid_out=0, ready_out=1, queued flits never emerge.
REQ-036 SHALL cover: port 0 FIFO full, head dequeued with valid_in[0]=1 -> not accepted that edge, count 3, accepted next edge.
